// File: rtl/fetch_unit_pkg.sv
// Shared processor package.
// Holds the NOP encoding, the default prefetch depth, the opcode/funct field
// positions used by the decode-stage controller, and the fetch queue entry type.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam int          DEFAULT_DEPTH = 4;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  // One prefetched instruction together with the address of the next one.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } fetch_entry_t;

  function automatic logic [5:0] op_field(input logic [31:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

  function automatic logic [5:0] funct_field(input logic [31:0] instr);
    return instr[FUNCT_HI:FUNCT_LO];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous in-order FIFO.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   push, din         write din at the tail
//   pop, dout         dout is the head; pop removes it (ignored when empty)
//   flush             empty the FIFO, overriding push and pop
//   full, empty,count occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is fine.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage plus IF/ID pipeline register.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   stallD                         decode stalled, hold IF/ID
//   redirectD, redirect_pc         taken branch/jump resolved in decode
//   imem_req, imem_addr,imem_ready request channel to instruction memory
//   imem_rvalid, imem_rdata        in-order response channel
//   instrD, opD, functD, pcplus4D, validD   decode-stage outputs
// A prefetch queue of {instr, pc+4} sits between memory and the IF/ID
// register; a tag FIFO remembers the pc of every in-flight request.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        redirectD,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [5:0]  opD,
  output logic [5:0]  functD,
  output logic [31:0] pcplus4D,
  output logic        validD
);

  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   fpc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic [CW:0]   in_use;

  logic          redir;
  logic          issue;
  logic          accept_rsp;
  logic          take;
  logic          bypass;

  fetch_entry_t  rsp_entry;
  fetch_entry_t  q_head;
  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;

  logic [31:0]   tag_head;
  logic          tag_push;
  logic          tag_pop;
  logic          tag_full;
  logic          tag_empty;
  logic [CW-1:0] tag_count_unused;

  // A stalled decode cannot act on its branch; it re-resolves next cycle.
  assign redir  = redirectD & ~stallD;
  assign in_use = {1'b0, cnt} + {1'b0, outst};

  // Issue depends only on registered occupancy and redir, never on the
  // response channel, so there is no rvalid-to-req combinational path.
  assign imem_req  = (in_use < (CW+1)'(DEPTH)) & ~redir;
  assign imem_addr = fpc;
  assign issue     = imem_req & imem_ready;

  // Responses still owed to pre-redirect requests are thrown away.
  assign accept_rsp = imem_rvalid & (drop == '0) & ~redir;
  assign rsp_entry  = '{instr: imem_rdata, pcplus4: tag_head + 32'd4};

  // The IF/ID register advances whenever decode is not stalled and not
  // redirecting; with an empty queue an accepted response goes straight to
  // the register's input instead of taking a queue slot.
  assign take   = ~stallD & ~redir;
  assign bypass = take & q_empty & accept_rsp;
  assign q_pop  = take & ~q_empty;
  assign q_push = accept_rsp & ~bypass & (~q_full | q_pop);

  assign tag_push = issue & ~tag_full;
  assign tag_pop  = accept_rsp & ~tag_empty;

  fetch_queue #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redir),
    .din   (rsp_entry),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (cnt)
  );

  fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .push  (tag_push),
    .pop   (tag_pop),
    .flush (redir),
    .din   (fpc),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count_unused)
  );

  // Fetch PC and in-flight bookkeeping. On redirect, drop is loaded with the
  // requests still outstanding after this cycle's response (no issue happens
  // in a redirect cycle), so their words are later discarded one by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc   <= RESET_PC;
      outst <= '0;
      drop  <= '0;
    end else begin
      outst <= outst + CW'(issue) - CW'(imem_rvalid);
      if (redir) begin
        drop <= outst - CW'(imem_rvalid);
      end else if (imem_rvalid && drop != '0) begin
        drop <= drop - CW'(1);
      end
      if (redir) begin
        fpc <= {redirect_pc[31:2], 2'b00};
      end else if (issue) begin
        fpc <= fpc + 32'd4;
      end
    end
  end

  // IF/ID register: hold on stall, bubble on redirect or when nothing is
  // available, otherwise take the queue head (or the bypassed response).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrD   <= NOP_INSTR;
      pcplus4D <= 32'h0;
      validD   <= 1'b0;
    end else if (!stallD) begin
      if (q_pop) begin
        instrD   <= q_head.instr;
        pcplus4D <= q_head.pcplus4;
        validD   <= 1'b1;
      end else if (bypass) begin
        instrD   <= rsp_entry.instr;
        pcplus4D <= rsp_entry.pcplus4;
        validD   <= 1'b1;
      end else begin
        instrD   <= NOP_INSTR;
        pcplus4D <= 32'h0;
        validD   <= 1'b0;
      end
    end
  end

  assign opD    = op_field(instrD);
  assign functD = funct_field(instrD);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit.
// The memory model answers every accepted request with its own address as
// the instruction word, after a programmable latency, in request order.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stallD = 1'b0;
  logic        redirectD = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instrD;
  logic [5:0]  opD;
  logic [5:0]  functD;
  logic [31:0] pcplus4D;
  logic        validD;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int          due_q[$];
  logic [31:0] addr_q[$];

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .stallD      (stallD),
    .redirectD   (redirectD),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instrD      (instrD),
    .opD         (opD),
    .functD      (functD),
    .pcplus4D    (pcplus4D),
    .validD      (validD)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive this cycle's inputs (called just after a rising edge) and let the
  // combinational outputs settle.
  task automatic apply_stimulus(input logic stall, input logic redir,
                                input logic [31:0] rpc, input logic ready);
    stallD      = stall;
    redirectD   = redir;
    redirect_pc = rpc;
    imem_ready  = ready;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = addr_q[0];
      void'(due_q.pop_front());
      void'(addr_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hdead_beef;
    end
    #1;
  endtask

  // Record an accepted request in the memory model, then move to the next cycle.
  task automatic advance();
    if (imem_req && imem_ready) begin
      due_q.push_back(cyc + lat);
      addr_q.push_back(imem_addr);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_from_reset();
    reset       = 1'b1;
    stallD      = 1'b0;
    redirectD   = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    due_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_instrD", instrD, 32'h0);
    check_output("rst_pcplus4D", pcplus4D, 32'h0);
    check_output("rst_validD", validD, 32'd0);
    check_output("rst_opD", opD, 32'd0);
    check_output("rst_functD", functD, 32'd0);
    check_output("rst_addr", imem_addr, 32'h0);

    // ---------------- streaming, latency 1 ----------------
    start_from_reset();
    lat = 1;
    apply_stimulus(0, 0, 0, 1);                       // c0
    check_output("s_c0_req", imem_req, 32'd1);
    check_output("s_c0_addr", imem_addr, 32'h0);
    check_output("s_c0_valid", validD, 32'd0);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c1
    check_output("s_c1_addr", imem_addr, 32'h4);
    check_output("s_c1_valid", validD, 32'd0);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c2
    check_output("s_c2_addr", imem_addr, 32'h8);
    check_output("s_c2_valid", validD, 32'd1);
    check_output("s_c2_instr", instrD, 32'h0);
    check_output("s_c2_pc4", pcplus4D, 32'h4);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c3
    check_output("s_c3_instr", instrD, 32'h4);
    check_output("s_c3_pc4", pcplus4D, 32'h8);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c4
    check_output("s_c4_instr", instrD, 32'h8);
    check_output("s_c4_pc4", pcplus4D, 32'hc);
    advance();

    // ---------------- decode stall for 5 cycles ----------------
    for (int i = 5; i <= 9; i++) begin
      apply_stimulus(1, 0, 0, 1);
      check_output("stall_hold_instr", instrD, 32'hc);
      check_output("stall_hold_pc4", pcplus4D, 32'h10);
      if (i >= 8) check_output("stall_req_stop", imem_req, 32'd0);
      else        check_output("stall_req_on", imem_req, 32'd1);
      advance();
    end
    check_output("stall_cnt_full", dut.cnt, 32'd4);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 0, 0, 1);                     // c10..c15
      check_output("release_instr", instrD, 32'hc + 32'(4 * i));
      check_output("release_pc4", pcplus4D, 32'h10 + 32'(4 * i));
      advance();
    end

    // ---------------- imem_ready low for 3 cycles ----------------
    start_from_reset();
    lat = 1;
    apply_stimulus(0, 0, 0, 1);                       // c0
    advance();
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus(0, 0, 0, 0);
      check_output("nrdy_req", imem_req, 32'd1);
      check_output("nrdy_addr", imem_addr, 32'h4);
      if (i == 2) begin
        check_output("nrdy_c2_valid", validD, 32'd1);
        check_output("nrdy_c2_pc4", pcplus4D, 32'h4);
      end
      if (i == 3) check_output("nrdy_c3_valid", validD, 32'd0);
      advance();
    end
    apply_stimulus(0, 0, 0, 1);                       // c4
    check_output("nrdy_c4_addr", imem_addr, 32'h4);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c5
    check_output("nrdy_c5_valid", validD, 32'd0);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c6
    check_output("nrdy_c6_instr", instrD, 32'h4);
    check_output("nrdy_c6_pc4", pcplus4D, 32'h8);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c7
    check_output("nrdy_c7_instr", instrD, 32'h8);
    check_output("nrdy_c7_valid", validD, 32'd1);
    advance();

    // ---------------- redirect with 2 in flight, latency 2 ----------------
    start_from_reset();
    lat = 2;
    for (int i = 0; i < 4; i++) begin                 // c0..c3
      apply_stimulus(0, 0, 0, 1);
      advance();
    end
    apply_stimulus(0, 1, 32'h100, 1);                 // c4: redirect
    check_output("redir_req_low", imem_req, 32'd0);
    check_output("redir_c4_instr", instrD, 32'h4);
    check_output("redir_c4_valid", validD, 32'd1);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c5
    check_output("redir_c5_req", imem_req, 32'd1);
    check_output("redir_c5_addr", imem_addr, 32'h100);
    check_output("redir_c5_valid", validD, 32'd0);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c6
    check_output("redir_c6_valid", validD, 32'd0);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c7
    check_output("redir_c7_valid", validD, 32'd0);
    advance();

    // c8: redirect while stalled must be ignored
    apply_stimulus(1, 1, 32'h200, 1);
    check_output("redir_tgt_instr", instrD, 32'h100);
    check_output("redir_tgt_pc4", pcplus4D, 32'h104);
    check_output("redir_tgt_valid", validD, 32'd1);
    check_output("stredir_req", imem_req, 32'd1);
    check_output("stredir_addr", imem_addr, 32'h10c);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c9
    check_output("stredir_hold", instrD, 32'h100);
    check_output("stredir_fpc", imem_addr, 32'h110);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c10
    check_output("stredir_c10_instr", instrD, 32'h104);
    check_output("stredir_c10_funct", functD, 32'h04);
    advance();
    apply_stimulus(0, 0, 0, 1);                       // c11
    check_output("stredir_c11_instr", instrD, 32'h108);
    check_output("stredir_c11_pc4", pcplus4D, 32'h10c);
    advance();

    // ---------------- reset pulse with the queue full ----------------
    start_from_reset();
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, 0, 0, 1);
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 0, 0, 1);
      advance();
    end
    apply_stimulus(1, 0, 0, 1);
    check_output("mrst_pre_cnt", dut.cnt, 32'd4);
    check_output("mrst_pre_valid", validD, 32'd1);
    reset = 1'b1;
    #1;
    check_output("mrst_cnt", dut.cnt, 32'd0);
    check_output("mrst_valid", validD, 32'd0);
    check_output("mrst_instr", instrD, 32'h0);
    check_output("mrst_addr", imem_addr, 32'h0);
    due_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    apply_stimulus(0, 0, 0, 1);
    check_output("mrst_c0_req", imem_req, 32'd1);
    check_output("mrst_c0_addr", imem_addr, 32'h0);
    advance();
    apply_stimulus(0, 0, 0, 1);
    check_output("mrst_c1_addr", imem_addr, 32'h4);
    advance();
    apply_stimulus(0, 0, 0, 1);
    check_output("mrst_c2_pc4", pcplus4D, 32'h4);
    check_output("mrst_c2_valid", validD, 32'd1);
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
